// File: rtl/bus_arb_pkg.sv
// Shared sizing helpers and types for the bus host arbiter.
package bus_arb_pkg;

   // Width of a host index; a single host still needs one bit.
   function automatic int host_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of an occupancy counter that must reach 'depth' itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int NrHostsDflt = 2;
   localparam int HostIdW     = host_id_w(NrHostsDflt);

   typedef logic [HostIdW-1:0] host_id_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs; head names the owner of the next response.
module bus_arb_id_fifo
   import bus_arb_pkg::*;
#(
   parameter int Depth = 2,
   parameter int Width = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          push_i,
   input  logic [Width-1:0]              data_i,
   input  logic                          pop_i,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [Width-1:0]              head_o,
   output logic [cnt_w(Depth)-1:0]       count_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = cnt_w(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy update; overflow pushes and underflow pops are dropped.
   always_comb begin
      push_ok  = push_i & ~full_o;
      pop_ok   = pop_i & ~empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
   end

   // Pointer, counter and storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device bus port between several hosts,
// with in-order routing of responses back to the issuing host.
module bus_host_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NrHosts-1:0]                     host_req_i,
   output logic [NrHosts-1:0]                     host_gnt_o,
   input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                     host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                     host_rvalid_o,
   output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                     host_err_o,
   output logic                                   out_req_o,
   input  logic                                   out_gnt_i,
   output logic [AddressWidth-1:0]                out_addr_o,
   output logic                                   out_we_o,
   output logic [DataWidth/8-1:0]                 out_be_o,
   output logic [DataWidth-1:0]                   out_wdata_o,
   input  logic                                   out_rvalid_i,
   input  logic [DataWidth-1:0]                   out_rdata_i,
   input  logic                                   out_err_i
);

   localparam int IdW  = host_id_w(NrHosts);
   localparam int CntW = cnt_w(MaxOutstanding);

   logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
   logic            lock_q, lock_d;
   logic [IdW-1:0]  lock_id_q, lock_id_d;
   logic [IdW-1:0]  winner;
   logic            req_ok, grant, rsp_pop;
   logic            fifo_full, fifo_empty;
   logic [IdW-1:0]  fifo_head;
   logic [CntW-1:0] fifo_count;

   // First requester at or after ptr, wrapping; scanning downward lets the
   // nearest requester overwrite farther ones.
   function automatic logic [IdW-1:0] find_first(input logic [NrHosts-1:0] req,
                                                 input logic [IdW-1:0]     ptr);
      int             idx;
      logic [IdW-1:0] sel;
      find_first = ptr;
      for (int i = NrHosts - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NrHosts) idx = idx - NrHosts;
         sel = IdW'(idx);
         if (req[sel]) find_first = sel;
      end
   endfunction

   // Winner selection: a locked winner is held, otherwise round-robin.
   // Nothing is offered while the ID FIFO is full, even if it pops this cycle.
   always_comb begin
      winner = lock_q ? lock_id_q : find_first(host_req_i, rr_ptr_q);
      req_ok = rst_ni & (lock_q | (|host_req_i)) & ~fifo_full;
      grant  = req_ok & out_gnt_i;
   end

   // Downstream command mux and zero-latency grant passthrough.
   always_comb begin
      out_req_o   = req_ok;
      out_addr_o  = '0;
      out_we_o    = 1'b0;
      out_be_o    = '0;
      out_wdata_o = '0;
      host_gnt_o  = '0;
      if (req_ok) begin
         out_addr_o  = host_addr_i[winner];
         out_we_o    = host_we_i[winner];
         out_be_o    = host_be_i[winner];
         out_wdata_o = host_wdata_i[winner];
      end
      if (grant) host_gnt_o[winner] = 1'b1;
   end

   // Pointer advances past the granted host; an unanswered offer locks the winner.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (grant) begin
         rr_ptr_d = (winner == IdW'(NrHosts - 1)) ? '0 : winner + IdW'(1);
         lock_d   = 1'b0;
      end else if (req_ok) begin
         lock_d    = 1'b1;
         lock_id_d = winner;
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   bus_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (grant),
      .data_i  (winner),
      .pop_i   (rsp_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   // Response demux: rvalid goes to the FIFO head, data and error are broadcast.
   // A response with nothing outstanding is routed nowhere.
   always_comb begin
      rsp_pop       = rst_ni & out_rvalid_i & ~fifo_empty;
      host_rvalid_o = '0;
      if (rsp_pop) host_rvalid_o[fifo_head] = 1'b1;
      for (int i = 0; i < NrHosts; i++) begin
         host_rdata_o[i] = rst_ni ? out_rdata_i : '0;
         host_err_o[i]   = rst_ni & out_err_i;
      end
   end

   // Protocol checks on the host and device sides.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(out_rvalid_i && fifo_empty))
            else $warning("bus_host_arbiter: response with no transaction outstanding");
         assert (!(lock_q && !host_req_i[lock_id_q]))
            else $error("bus_host_arbiter: locked host withdrew its request");
         assert (fifo_empty == (fifo_count == '0))
            else $error("bus_host_arbiter: id fifo occupancy inconsistent");
      end
   end

endmodule
